// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, idle line level, legal parameter limits
// and the parity helper, common to uart_tx and the future uart_rx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_t;

    localparam logic LINE_IDLE     = 1'b1;
    localparam int   DATA_BITS_MIN = 5;
    localparam int   DATA_BITS_MAX = 8;
    localparam int   STOP_BITS_MIN = 1;
    localparam int   STOP_BITS_MAX = 2;

    // Even parity is the XOR of the payload; odd parity is its inverse.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional parity, STOP_BITS stop bits.
// Optional parity bit compiled in with macro UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          state_r, state_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [2:0]           bit_cnt_r, bit_cnt_s;
    logic                 stop_cnt_r, stop_cnt_s;
    logic                 tx_r, tx_s;
    logic                 done_s;
    logic                 tx_done_r;
    logic                 tx_busy_r;
    logic                 in_ready_r;

`ifdef UART_TX_PARITY_EN
    logic                 parity_r, parity_s;
`else
    // PARITY_ODD has no effect when parity is not compiled in.
    if (PARITY_ODD) begin : g_parity_odd_ignored
    end
`endif

    // Next-state, next-line-level and datapath updates; every bit boundary is a sampled baud_tick.
    always_comb begin
        state_s    = state_r;
        shift_s    = shift_r;
        bit_cnt_s  = bit_cnt_r;
        stop_cnt_s = stop_cnt_r;
        tx_s       = tx_r;
        done_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_s   = parity_r;
`endif
        case (state_r)
            IDLE: begin
                tx_s = LINE_IDLE;
                if (in_valid) begin
                    state_s    = SYNC;
                    shift_s    = in_data;
                    bit_cnt_s  = 3'd0;
                    stop_cnt_s = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_s   = parity_bit(8'(in_data), PARITY_ODD);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SYNC: begin
                if (baud_tick) begin
                    state_s = START;
                    tx_s    = 1'b0;
                end else begin
                    state_s = SYNC;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_s   = DATA;
                    bit_cnt_s = 3'd0;
                    tx_s      = shift_r[0];
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_s    = PARITY;
                        tx_s       = parity_r;
`else
                        state_s    = STOP;
                        tx_s       = LINE_IDLE;
`endif
                        stop_cnt_s = 1'b0;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        shift_s   = {1'b0, shift_r[DATA_BITS-1:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    state_s    = STOP;
                    stop_cnt_s = 1'b0;
                    tx_s       = LINE_IDLE;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                tx_s = LINE_IDLE;
                if (baud_tick) begin
                    if (stop_cnt_r == LAST_STOP) begin
                        state_s    = IDLE;
                        stop_cnt_s = 1'b0;
                        done_s     = 1'b1;
                    end else begin
                        stop_cnt_s = stop_cnt_r + 1'b1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                tx_s    = LINE_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any frame with the line released high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            tx_r       <= LINE_IDLE;
            tx_done_r  <= 1'b0;
            tx_busy_r  <= 1'b0;
            in_ready_r <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            bit_cnt_r  <= bit_cnt_s;
            stop_cnt_r <= stop_cnt_s;
            tx_r       <= tx_s;
            tx_done_r  <= done_s;
            tx_busy_r  <= (state_s != IDLE);
            in_ready_r <= (state_s == IDLE);
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_s;
`endif
        end
    end

    assign tx       = tx_r;
    assign tx_done  = tx_done_r;
    assign tx_busy  = tx_busy_r;
    assign in_ready = in_ready_r;

endmodule
